// File: rtl/dxl_bus_scheduler.sv
// Dynamixel half-duplex bus scheduler: arbitrates host one-shot packets
// against a round-robin position poller, with timeout, retry and gap.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   poll_en               enables autonomous position polling (level)
//   host_req/host_word*   host packet request, held until host_ack
//   host_ack/host_done    launch / completion pulses for the host packet
//   host_fail             sticky failure of last host transaction
//   host_rx_word*         reply words of last host transaction
//   tx_start/tx_word*     launch pulse and packet words to the transceiver
//   rx_done/rx_fail/rx_word*  reply status and words from the transceiver
//   pos_flat/pos_valid/pos_err  cached servo positions and status
//   busy                  high whenever a transaction is being handled
module dxl_bus_scheduler #(
    parameter int N_SERVO      = 4,
    parameter int ID_BASE      = 1,
    parameter int POLL_PERIOD  = 500000,
    parameter int RESP_TIMEOUT = 200000,
    parameter int GAP_CYCLES   = 1000,
    parameter int MAX_RETRY    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 poll_en,
    input  logic                 host_req,
    input  logic [31:0]          host_word1,
    input  logic [31:0]          host_word2,
    output logic                 host_ack,
    output logic                 host_done,
    output logic                 host_fail,
    output logic [31:0]          host_rx_word1,
    output logic [31:0]          host_rx_word2,
    output logic                 tx_start,
    output logic [31:0]          tx_word1,
    output logic [31:0]          tx_word2,
    input  logic                 rx_done,
    input  logic                 rx_fail,
    input  logic [31:0]          rx_word1,
    input  logic [31:0]          rx_word2,
    output logic [16*N_SERVO-1:0] pos_flat,
    output logic [N_SERVO-1:0]   pos_valid,
    output logic [N_SERVO-1:0]   pos_err,
    output logic                 busy
);

    localparam int TW   = $clog2(POLL_PERIOD + 1);
    localparam int CMAX = (RESP_TIMEOUT > GAP_CYCLES) ?
                          RESP_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int KW   = (N_SERVO > 1) ? $clog2(N_SERVO) : 1;
    localparam int RW   = (MAX_RETRY > 0) ?
                          $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_GAP
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [TW-1:0]  tmr_q;
    logic [CW-1:0]  cyc_q;
    logic [KW-1:0]  k_q;
    logic [RW-1:0]  retry_q;
    logic           sweep_q;
    logic           is_host_q;
    logic           failed_q;
    logic [31:0]    rx1_q;
    logic [31:0]    rx2_q;
    logic [15:0]    pos_q [N_SERVO];

    logic           sweep_due;
    logic           poll_want;
    logic           grant_host;
    logic           grant_poll;
    logic           timed_out;
    logic           resp_end;
    logic           resp_fail;
    logic           poll_ok;
    logic           last_k;
    logic           retry_left;
    logic [7:0]     cur_id;
    logic [31:0]    poll_w1;

    assign sweep_due = poll_en && (tmr_q == TW'(POLL_PERIOD));
    // A started sweep keeps the poller asking until the last servo.
    assign poll_want = poll_en && (sweep_q || sweep_due);

    assign cur_id  = 8'(ID_BASE) + 8'(k_q);
    // READ_DATA of 2 bytes at address 0x24: id+4+2+0x24+2 = id+0x2C.
    assign poll_w1 = {~(cur_id + 8'h2C), 8'h02, 8'h04, cur_id};

    assign timed_out = (cyc_q >= CW'(RESP_TIMEOUT - 1));
    assign resp_end  = rx_done || rx_fail || timed_out;
    // A fail pulse always wins, even alongside rx_done.
    assign resp_fail = rx_fail || (!rx_done && timed_out);

    assign poll_ok    = !failed_q && (rx1_q[7:0] == cur_id) &&
                        (rx1_q[23:16] == 8'h00);
    assign last_k     = (k_q == KW'(N_SERVO - 1));
    assign retry_left = (retry_q < RW'(MAX_RETRY));

    always_comb begin
        state_d    = state_q;
        grant_host = 1'b0;
        grant_poll = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (host_req || poll_want) state_d = S_ARB;
            end
            S_ARB: begin
                if (host_req) begin
                    grant_host = 1'b1;
                    state_d    = S_LAUNCH;
                end else if (poll_want) begin
                    grant_poll = 1'b1;
                    state_d    = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (resp_end) state_d = S_CHECK;
            end
            S_CHECK: state_d = S_GAP;
            S_GAP: begin
                if (cyc_q >= CW'(GAP_CYCLES - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign host_ack = grant_host;
    assign tx_start = (state_q == S_LAUNCH);
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Shared cycle counter: response timeout, then inter-frame gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
        end else if (state_q == S_LAUNCH || state_q == S_CHECK) begin
            cyc_q <= '0;
        end else if (state_q == S_WAIT || state_q == S_GAP) begin
            if (cyc_q != CW'(CMAX)) cyc_q <= cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= '0;
        end else if (!poll_en) begin
            tmr_q <= '0;
        end else if (grant_poll && !sweep_q) begin
            tmr_q <= '0;
        end else if (tmr_q != TW'(POLL_PERIOD)) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    // Sweep progress. Dropping poll_en abandons the rest of the sweep
    // once the bus is back in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_q <= 1'b0;
            k_q     <= '0;
            retry_q <= '0;
        end else if (!poll_en && state_q == S_IDLE) begin
            sweep_q <= 1'b0;
            k_q     <= '0;
            retry_q <= '0;
        end else if (grant_poll && !sweep_q) begin
            sweep_q <= 1'b1;
        end else if (state_q == S_CHECK && !is_host_q) begin
            if (!poll_ok && retry_left) begin
                retry_q <= retry_q + 1'b1;
            end else begin
                retry_q <= '0;
                if (last_k) begin
                    k_q     <= '0;
                    sweep_q <= 1'b0;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_word1      <= '0;
            tx_word2      <= '0;
            is_host_q     <= 1'b0;
            failed_q      <= 1'b0;
            rx1_q         <= '0;
            rx2_q         <= '0;
            host_done     <= 1'b0;
            host_fail     <= 1'b0;
            host_rx_word1 <= '0;
            host_rx_word2 <= '0;
        end else begin
            host_done <= (state_q == S_CHECK) && is_host_q;
            if (grant_host) begin
                tx_word1  <= host_word1;
                tx_word2  <= host_word2;
                is_host_q <= 1'b1;
                host_fail <= 1'b0;
            end else if (grant_poll) begin
                tx_word1  <= poll_w1;
                tx_word2  <= 32'h0000_0224;
                is_host_q <= 1'b0;
            end
            if (state_q == S_WAIT && resp_end) begin
                failed_q <= resp_fail;
                rx1_q    <= rx_word1;
                rx2_q    <= rx_word2;
            end
            if (state_q == S_CHECK && is_host_q) begin
                host_rx_word1 <= rx1_q;
                host_rx_word2 <= rx2_q;
                host_fail     <= failed_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_valid <= '0;
            pos_err   <= '0;
            for (int i = 0; i < N_SERVO; i++) pos_q[i] <= '0;
        end else if (state_q == S_CHECK && !is_host_q) begin
            for (int i = 0; i < N_SERVO; i++) begin
                if (k_q == KW'(i)) begin
                    if (poll_ok) begin
                        pos_q[i]     <= rx2_q[15:0];
                        pos_valid[i] <= 1'b1;
                        pos_err[i]   <= 1'b0;
                    end else if (!retry_left) begin
                        pos_err[i] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_SERVO; g++) begin : g_pos
        assign pos_flat[16*g +: 16] = pos_q[g];
    end

endmodule
